// File: rtl/vote_tally.sv
`default_nettype none
// ============================================================================
//  Module      : vote_tally
//  Description : Voting-machine front end. Captures candidate selection and
//                cast presses, keeps one 4-digit BCD tally per candidate and
//                drives the value/mode inputs of a 4-digit 7-segment decoder.
//  Revision    : 1.0  initial release
// ============================================================================
module vote_tally #(
  parameter int NUM_CAND    = 4,
  parameter int CONF_CYCLES = 50000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CAND-1:0] vote_btn,
  input  logic                cast_btn,
  input  logic                view_en,
  input  logic [1:0]          view_sel,
  output logic [16:0]         disp_value,
  output logic [2:0]          disp_mode,
  output logic                vote_ok,
  output logic [NUM_CAND-1:0] sat
);

  // Timer only ever holds CONF_CYCLES-1 down to 0.
  localparam int               TMR_W    = (CONF_CYCLES > 1) ? $clog2(CONF_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CONF_CYCLES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SELECT  = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;
  localparam logic [1:0] ST_CONFIRM = 2'd3;

  localparam logic [2:0] MODE_NUM   = 3'b111;
  localparam logic [2:0] MODE_CONF  = 3'b101;
  localparam logic [2:0] MODE_BLANK = 3'b000;

  localparam logic [15:0] CNT_MAX = 16'h9999;

  logic [1:0]          state;
  logic [1:0]          sel;
  logic [TMR_W-1:0]    timer;
  logic [NUM_CAND-1:0] vote_q;
  logic                cast_q;
  logic [15:0]         cnt [NUM_CAND];

  logic [NUM_CAND-1:0] vote_rise;
  logic                cast_rise;
  logic [2:0]          rise_cnt;
  logic [1:0]          rise_idx;
  logic                one_rise;
  logic                any_rise;
  logic [15:0]         cnt_sel;
  logic [15:0]         cnt_view;

  // BCD increment with per-digit carry; saturates at 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != CNT_MAX) begin
      for (int d = 0; d < 4; d++) begin
        if (carry) begin
          if (r[d*4 +: 4] == 4'd9) begin
            r[d*4 +: 4] = 4'd0;
          end else begin
            r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign vote_rise = vote_btn & ~vote_q;
  assign cast_rise = cast_btn & ~cast_q;
  assign one_rise  = (rise_cnt == 3'd1);
  assign any_rise  = |vote_rise;
  assign vote_ok   = (state == ST_COMMIT);

  // Count simultaneous vote rises and remember which button rose.
  always_comb begin
    rise_cnt = 3'd0;
    rise_idx = 2'd0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (vote_rise[i]) begin
        rise_cnt = rise_cnt + 3'd1;
        rise_idx = 2'(i);
      end
    end
  end

  // Counter muxes; an out-of-range view index reads as 0000.
  always_comb begin
    cnt_sel  = 16'h0000;
    cnt_view = 16'h0000;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (sel == 2'(i))      cnt_sel  = cnt[i];
      if (view_sel == 2'(i)) cnt_view = cnt[i];
    end
  end

  // Button history tracks the inputs every cycle, reset included, so a
  // button held across reset leaves no pending edge afterwards.
  always_ff @(posedge clk) begin
    vote_q <= vote_btn;
    cast_q <= cast_btn;
  end

  // Selection / commit / confirm-banner state machine.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sel   <= 2'd0;
      timer <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (one_rise) begin
            sel   <= rise_idx;
            state <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (any_rise) begin
            if (one_rise) sel <= rise_idx;
          end else if (cast_rise) begin
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          timer <= TMR_LOAD;
          state <= ST_CONFIRM;
        end
        ST_CONFIRM: begin
          if (timer == '0) begin
            state <= ST_IDLE;
            sel   <= 2'd0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Tally update: the selected counter advances during COMMIT only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CAND; i++) cnt[i] <= 16'h0000;
    end else if (state == ST_COMMIT) begin
      for (int i = 0; i < NUM_CAND; i++) begin
        if (sel == 2'(i)) cnt[i] <= bcd_inc(cnt[i]);
      end
    end
  end

  // Saturation flags, one cycle behind the counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat <= '0;
    end else begin
      for (int i = 0; i < NUM_CAND; i++) sat[i] <= (cnt[i] == CNT_MAX);
    end
  end

  // Registered decoder drive derived from the current state and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_value <= 17'd0;
      disp_mode  <= MODE_BLANK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (view_en) begin
            disp_value <= {1'b0, cnt_view};
            disp_mode  <= MODE_NUM;
          end else begin
            disp_value <= 17'd0;
            disp_mode  <= MODE_BLANK;
          end
        end
        ST_SELECT: begin
          disp_value <= {14'd0, {1'b0, sel} + 3'd1};
          disp_mode  <= MODE_NUM;
        end
        ST_COMMIT: begin
          disp_value <= {1'b0, cnt_sel};
          disp_mode  <= MODE_NUM;
        end
        ST_CONFIRM: begin
          disp_value <= 17'd0;
          disp_mode  <= MODE_CONF;
        end
        default: begin
          disp_value <= 17'd0;
          disp_mode  <= MODE_BLANK;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vote_tally.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vote_tally
//  Description : Directed self-checking bench for vote_tally. A second
//                instance with a one-cycle banner reaches the 9999 limit
//                in a reasonable number of clocks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vote_tally;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  vote_btn;
  logic        cast_btn;
  logic        view_en;
  logic [1:0]  view_sel;
  logic [16:0] disp_value;
  logic [2:0]  disp_mode;
  logic        vote_ok;
  logic [3:0]  sat;

  logic        f_rst_n;
  logic [3:0]  f_vote;
  logic        f_cast;
  logic        f_view_en;
  logic [1:0]  f_view_sel;
  logic [16:0] f_value;
  logic [2:0]  f_mode;
  logic        f_vote_ok;
  logic [3:0]  f_sat;

  int total = 0;
  int bad   = 0;
  int ok_pulses = 0;
  int f_pulses  = 0;

  vote_tally #(.NUM_CAND(4), .CONF_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .vote_btn(vote_btn), .cast_btn(cast_btn),
    .view_en(view_en), .view_sel(view_sel), .disp_value(disp_value),
    .disp_mode(disp_mode), .vote_ok(vote_ok), .sat(sat)
  );

  vote_tally #(.NUM_CAND(4), .CONF_CYCLES(1)) dut_fast (
    .clk(clk), .rst_n(f_rst_n), .vote_btn(f_vote), .cast_btn(f_cast),
    .view_en(f_view_en), .view_sel(f_view_sel), .disp_value(f_value),
    .disp_mode(f_mode), .vote_ok(f_vote_ok), .sat(f_sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full vote on the main instance; ends with the display back in IDLE.
  task automatic main_vote(input int idx);
    vote_btn = 4'(1 << idx);
    tick();
    vote_btn = 4'b0000;
    cast_btn = 1'b1;
    tick();
    if (vote_ok) ok_pulses++;
    cast_btn = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (vote_ok) ok_pulses++;
    end
  endtask

  // One full vote on the fast instance (press, cast, commit, confirm).
  task automatic fast_vote(input int idx);
    f_vote = 4'(1 << idx);
    tick();
    f_vote = 4'b0000;
    f_cast = 1'b1;
    tick();
    if (f_vote_ok) f_pulses++;
    f_cast = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; f_rst_n = 1'b0;
    vote_btn = 4'b0000; cast_btn = 1'b0; view_en = 1'b0; view_sel = 2'd0;
    f_vote = 4'b0000; f_cast = 1'b0; f_view_en = 1'b0; f_view_sel = 2'd0;
    repeat (3) tick();
    rst_n = 1'b1; f_rst_n = 1'b1;
    total++; if (disp_mode !== 3'b000) begin bad++; $display("FAIL reset_mode got=%b want=000", disp_mode); end
    total++; if (disp_value !== 17'd0) begin bad++; $display("FAIL reset_value got=%h want=0", disp_value); end
    total++; if (vote_ok !== 1'b0 || sat !== 4'b0000) begin bad++; $display("FAIL reset_flags got ok=%b sat=%b want 0/0000", vote_ok, sat); end
  endtask

  task automatic test_view_idle();
    view_en = 1'b1; view_sel = 2'd2;
    tick();
    total++; if (disp_mode !== 3'b111) begin bad++; $display("FAIL view_mode got=%b want=111", disp_mode); end
    total++; if (disp_value !== 17'd0) begin bad++; $display("FAIL view_value got=%h want=0", disp_value); end
    total++; if (vote_ok !== 1'b0 || sat !== 4'b0000) begin bad++; $display("FAIL view_flags got ok=%b sat=%b want 0/0000", vote_ok, sat); end
  endtask

  task automatic test_single_vote();
    int conf_cnt;
    int pulses;
    view_en = 1'b0;
    vote_btn = 4'b0010;
    tick();
    vote_btn = 4'b0000;
    tick();
    total++; if (disp_value !== 17'h00002 || disp_mode !== 3'b111) begin bad++; $display("FAIL select_show got=%h/%b want=00002/111", disp_value, disp_mode); end
    cast_btn = 1'b1;
    tick();
    cast_btn = 1'b0;
    total++; if (vote_ok !== 1'b1) begin bad++; $display("FAIL commit_ok got=%b want=1", vote_ok); end
    pulses = 1;
    tick();
    total++; if (disp_value !== 17'd0 || disp_mode !== 3'b111) begin bad++; $display("FAIL commit_show got=%h/%b want=00000/111", disp_value, disp_mode); end
    conf_cnt = 0;
    if (vote_ok) pulses++;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (disp_mode === 3'b101) conf_cnt++;
      if (vote_ok) pulses++;
    end
    total++; if (conf_cnt != 4) begin bad++; $display("FAIL conf_len got=%0d want=4", conf_cnt); end
    total++; if (pulses != 1) begin bad++; $display("FAIL ok_pulses got=%0d want=1", pulses); end
    total++; if (disp_mode !== 3'b000) begin bad++; $display("FAIL back_idle got=%b want=000", disp_mode); end
    view_en = 1'b1; view_sel = 2'd1;
    tick();
    total++; if (disp_value !== 17'h00001 || disp_mode !== 3'b111) begin bad++; $display("FAIL tally1 got=%h/%b want=00001/111", disp_value, disp_mode); end
  endtask

  task automatic test_bcd_carry();
    ok_pulses = 0;
    view_en = 1'b1; view_sel = 2'd0;
    for (int n = 0; n < 9; n++) main_vote(0);
    total++; if (disp_value !== 17'h00009) begin bad++; $display("FAIL tally_9 got=%h want=00009", disp_value); end
    main_vote(0);
    total++; if (disp_value !== 17'h00010) begin bad++; $display("FAIL tally_10 got=%h want=00010", disp_value); end
    total++; if (ok_pulses != 10) begin bad++; $display("FAIL pulses_10 got=%0d want=10", ok_pulses); end
    for (int n = 0; n < 90; n++) main_vote(0);
    total++; if (disp_value !== 17'h00100) begin bad++; $display("FAIL tally_100 got=%h want=00100", disp_value); end
    for (int n = 0; n < 899; n++) main_vote(0);
    total++; if (disp_value !== 17'h00999) begin bad++; $display("FAIL tally_999 got=%h want=00999", disp_value); end
    main_vote(0);
    total++; if (disp_value !== 17'h01000) begin bad++; $display("FAIL tally_1000 got=%h want=01000", disp_value); end
    view_sel = 2'd1;
    tick();
    total++; if (disp_value !== 17'h00001) begin bad++; $display("FAIL other_cand got=%h want=00001", disp_value); end
  endtask

  task automatic test_reset_mid_confirm();
    vote_btn = 4'b0100;
    tick();
    vote_btn = 4'b0000; cast_btn = 1'b1;
    tick();
    cast_btn = 1'b0; vote_btn = 4'b0010;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    total++; if (disp_mode !== 3'b000 || disp_value !== 17'd0) begin bad++; $display("FAIL rst_conf_show got=%h/%b want=00000/000", disp_value, disp_mode); end
    total++; if (vote_ok !== 1'b0) begin bad++; $display("FAIL rst_conf_ok got=%b want=0", vote_ok); end
    rst_n = 1'b1; view_en = 1'b0;
    tick();
    tick();
    total++; if (disp_mode !== 3'b000) begin bad++; $display("FAIL held_through_rst got=%b want=000", disp_mode); end
    view_en = 1'b1; view_sel = 2'd0;
    tick();
    total++; if (disp_value !== 17'd0) begin bad++; $display("FAIL cleared_c0 got=%h want=0", disp_value); end
    view_sel = 2'd1;
    tick();
    total++; if (disp_value !== 17'd0) begin bad++; $display("FAIL cleared_c1 got=%h want=0", disp_value); end
    view_sel = 2'd2;
    tick();
    total++; if (disp_value !== 17'd0) begin bad++; $display("FAIL cleared_c2 got=%h want=0", disp_value); end
    vote_btn = 4'b0000;
    tick();
  endtask

  task automatic test_multi_rise();
    view_en = 1'b0;
    vote_btn = 4'b0011;
    tick();
    vote_btn = 4'b0000;
    tick();
    total++; if (disp_mode !== 3'b000) begin bad++; $display("FAIL double_rise got=%b want=000", disp_mode); end
    cast_btn = 1'b1;
    tick();
    cast_btn = 1'b0;
    total++; if (vote_ok !== 1'b0) begin bad++; $display("FAIL idle_cast_ok got=%b want=0", vote_ok); end
    tick();
    total++; if (disp_mode !== 3'b000) begin bad++; $display("FAIL idle_cast_mode got=%b want=000", disp_mode); end
    vote_btn = 4'b0100;
    tick();
    vote_btn = 4'b0000;
    tick();
    total++; if (disp_value !== 17'h00003 || disp_mode !== 3'b111) begin bad++; $display("FAIL select3 got=%h/%b want=00003/111", disp_value, disp_mode); end
    vote_btn = 4'b0001; cast_btn = 1'b1;
    tick();
    total++; if (vote_ok !== 1'b0) begin bad++; $display("FAIL vote_cast_ok1 got=%b want=0", vote_ok); end
    vote_btn = 4'b0000; cast_btn = 1'b0;
    tick();
    total++; if (vote_ok !== 1'b0) begin bad++; $display("FAIL vote_cast_ok2 got=%b want=0", vote_ok); end
    total++; if (disp_value !== 17'h00001 || disp_mode !== 3'b111) begin bad++; $display("FAIL reselect1 got=%h/%b want=00001/111", disp_value, disp_mode); end
  endtask

  task automatic test_saturation();
    f_view_en = 1'b1; f_view_sel = 2'd3;
    f_pulses = 0;
    for (int n = 0; n < 9998; n++) fast_vote(3);
    tick();
    total++; if (f_value !== 17'h09998 || f_sat !== 4'b0000) begin bad++; $display("FAIL tally_9998 got=%h sat=%b want=09998/0000", f_value, f_sat); end
    fast_vote(3);
    tick();
    total++; if (f_value !== 17'h09999) begin bad++; $display("FAIL tally_9999 got=%h want=09999", f_value); end
    total++; if (f_sat !== 4'b1000) begin bad++; $display("FAIL sat3 got=%b want=1000", f_sat); end
    fast_vote(3);
    tick();
    total++; if (f_value !== 17'h09999) begin bad++; $display("FAIL sat_hold got=%h want=09999", f_value); end
    total++; if (f_pulses != 10000) begin bad++; $display("FAIL sat_pulses got=%0d want=10000", f_pulses); end
    total++; if (f_sat !== 4'b1000) begin bad++; $display("FAIL sat_stay got=%b want=1000", f_sat); end
  endtask

  initial begin
    test_reset();
    test_view_idle();
    test_single_vote();
    test_bcd_carry();
    test_reset_mid_confirm();
    test_multi_rise();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
